// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, framebuffer geometry and colour helpers for the
// 160x120 3-bit display path (scanout and plot writer).
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_ADDR_W = 15;
  localparam int COLOUR_W  = 3;
  localparam int CNT_W     = 10;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  // Scan flags carried alongside the read pipeline; all active-high internally.
  typedef struct packed {
    logic visible;
    logic hSync;
    logic vSync;
    logic frameStart;
  } scan_flags_t;

  function automatic rgb_t expandColour(input logic [COLOUR_W-1:0] d);
    rgb_t c;
    c.red   = {8{d[2]}};
    c.green = {8{d[1]}};
    c.blue  = {8{d[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Bundles for the raster position link (counter -> scanout) and the
// framebuffer read port (scanout -> memory).
interface vga_sync_if;
  import vga_timing_pkg::*;

  logic [CNT_W-1:0] hCount;
  logic [CNT_W-1:0] vCount;
  logic             visible;
  logic             hSyncActive;
  logic             vSyncActive;

  modport master (output hCount, output vCount, output visible,
                  output hSyncActive, output vSyncActive);
  modport slave  (input hCount, input vCount, input visible,
                  input hSyncActive, input vSyncActive);
endinterface

interface vga_fb_if;
  import vga_timing_pkg::*;

  logic [FB_ADDR_W-1:0] rdAddr;
  logic [COLOUR_W-1:0]  rdData;

  modport master (output rdAddr, input rdData);
  modport slave  (input rdAddr, output rdData);
endinterface

// File: rtl/vga_sync_counter.sv
// Raster position counters and the raw (undelayed) visible/sync flags
// decoded from them.
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int P_H_VISIBLE = H_VISIBLE,
  parameter int P_H_FRONT   = H_FRONT,
  parameter int P_H_SYNC    = H_SYNC,
  parameter int P_H_BACK    = H_BACK,
  parameter int P_V_VISIBLE = V_VISIBLE,
  parameter int P_V_FRONT   = V_FRONT,
  parameter int P_V_SYNC    = V_SYNC,
  parameter int P_V_BACK    = V_BACK
) (
  input  logic         iClock,
  input  logic         iResetn,
  vga_sync_if.master   sync
);

  localparam int H_TOTAL = P_H_VISIBLE + P_H_FRONT + P_H_SYNC + P_H_BACK;
  localparam int V_TOTAL = P_V_VISIBLE + P_V_FRONT + P_V_SYNC + P_V_BACK;

  logic [CNT_W-1:0] r_hCount;
  logic [CNT_W-1:0] r_vCount;

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      r_hCount <= '0;
      r_vCount <= '0;
    end else if (r_hCount == CNT_W'(H_TOTAL - 1)) begin
      r_hCount <= '0;
      if (r_vCount == CNT_W'(V_TOTAL - 1))
        r_vCount <= '0;
      else
        r_vCount <= r_vCount + 1'b1;
    end else begin
      r_hCount <= r_hCount + 1'b1;
    end
  end

  assign sync.hCount  = r_hCount;
  assign sync.vCount  = r_vCount;
  assign sync.visible = (r_hCount < CNT_W'(P_H_VISIBLE)) &&
                        (r_vCount < CNT_W'(P_V_VISIBLE));
  assign sync.hSyncActive = (r_hCount >= CNT_W'(P_H_VISIBLE + P_H_FRONT)) &&
                            (r_hCount <  CNT_W'(P_H_VISIBLE + P_H_FRONT + P_H_SYNC));
  assign sync.vSyncActive = (r_vCount >= CNT_W'(P_V_VISIBLE + P_V_FRONT)) &&
                            (r_vCount <  CNT_W'(P_V_VISIBLE + P_V_FRONT + P_V_SYNC));

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer reader and 640x480 VGA timing generator; each stored pixel is
// replicated 4x4 and all outputs leave registered, three clocks after the count.
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int P_H_VISIBLE = H_VISIBLE,
  parameter int P_H_FRONT   = H_FRONT,
  parameter int P_H_SYNC    = H_SYNC,
  parameter int P_H_BACK    = H_BACK,
  parameter int P_V_VISIBLE = V_VISIBLE,
  parameter int P_V_FRONT   = V_FRONT,
  parameter int P_V_SYNC    = V_SYNC,
  parameter int P_V_BACK    = V_BACK,
  parameter int P_FB_WIDTH  = FB_WIDTH
) (
  input  logic                 iClock,
  input  logic                 iResetn,
  output logic [FB_ADDR_W-1:0] oRdAddr,
  input  logic [COLOUR_W-1:0]  iRdData,
  output logic [7:0]           oRed,
  output logic [7:0]           oGreen,
  output logic [7:0]           oBlue,
  output logic                 oHSync,
  output logic                 oVSync,
  output logic                 oBlank_n,
  output logic                 oFrameStart
);

  vga_sync_if w_sync ();

  vga_sync_counter #(
    .P_H_VISIBLE (P_H_VISIBLE),
    .P_H_FRONT   (P_H_FRONT),
    .P_H_SYNC    (P_H_SYNC),
    .P_H_BACK    (P_H_BACK),
    .P_V_VISIBLE (P_V_VISIBLE),
    .P_V_FRONT   (P_V_FRONT),
    .P_V_SYNC    (P_V_SYNC),
    .P_V_BACK    (P_V_BACK)
  ) u_counter (
    .iClock  (iClock),
    .iResetn (iResetn),
    .sync    (w_sync)
  );

  logic [7:0]           w_fbX;
  logic [6:0]           w_fbY;
  logic [FB_ADDR_W-1:0] w_pixAddr;
  logic                 w_frameFirst;
  scan_flags_t          w_flags;
  rgb_t                 w_rgb;

  // Dropping the low two count bits gives the 4x4 pixel replication.
  assign w_fbX        = w_sync.hCount[9:2];
  assign w_fbY        = w_sync.vCount[8:2];
  assign w_pixAddr    = FB_ADDR_W'(w_fbY) * FB_ADDR_W'(P_FB_WIDTH) + FB_ADDR_W'(w_fbX);
  assign w_frameFirst = (w_sync.hCount == '0) && (w_sync.vCount == '0);
  assign w_flags      = '{visible:    w_sync.visible,
                          hSync:      w_sync.hSyncActive,
                          vSync:      w_sync.vSyncActive,
                          frameStart: w_frameFirst};
  assign w_rgb        = expandColour(iRdData);

  logic [FB_ADDR_W-1:0] r_rdAddr;
  scan_flags_t          r_stage1;
  scan_flags_t          r_stage2;
  logic [7:0]           r_red;
  logic [7:0]           r_green;
  logic [7:0]           r_blue;
  logic                 r_hSync;
  logic                 r_vSync;
  logic                 r_blank_n;
  logic                 r_frameStart;

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn)
      r_rdAddr <= '0;
    else if (w_sync.visible)
      r_rdAddr <= w_pixAddr;
  end

  // Flags ride two stages here and the output register is the third, matching
  // the address register plus the one-cycle memory read.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      r_stage1 <= '0;
      r_stage2 <= '0;
    end else begin
      r_stage1 <= w_flags;
      r_stage2 <= r_stage1;
    end
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      r_red        <= '0;
      r_green      <= '0;
      r_blue       <= '0;
      r_hSync      <= 1'b1;
      r_vSync      <= 1'b1;
      r_blank_n    <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_red        <= r_stage2.visible ? w_rgb.red   : 8'h00;
      r_green      <= r_stage2.visible ? w_rgb.green : 8'h00;
      r_blue       <= r_stage2.visible ? w_rgb.blue  : 8'h00;
      r_hSync      <= ~r_stage2.hSync;
      r_vSync      <= ~r_stage2.vSync;
      r_blank_n    <= r_stage2.visible;
      r_frameStart <= r_stage2.frameStart;
    end
  end

  assign oRdAddr     = r_rdAddr;
  assign oRed        = r_red;
  assign oGreen      = r_green;
  assign oBlue       = r_blue;
  assign oHSync      = r_hSync;
  assign oVSync      = r_vSync;
  assign oBlank_n    = r_blank_n;
  assign oFrameStart = r_frameStart;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: reset values, first pixel, sync placement,
// address sweep, full-frame colour model and mid-frame reset recovery.
module tb_vga_scanout;

  // Vertical timing is shortened so several frames fit in a short run.
  localparam int V_VIS = 16;
  localparam int V_FR  = 2;
  localparam int V_SY  = 2;
  localparam int V_BK  = 3;
  localparam int V_TOT = V_VIS + V_FR + V_SY + V_BK;
  localparam int H_TOT = 800;
  localparam int FRAME = H_TOT * V_TOT;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       fs;
  } expOut_t;

  logic       clock;
  logic       resetn;
  logic       tieMode;
  logic       chkOn;
  logic [2:0] ramQ;
  logic [7:0] oRed, oGreen, oBlue;
  logic       oHSync, oVSync, oBlank_n, oFrameStart;
  int         k;

  int assertCount = 0;
  int failCount   = 0;
  int pixErr      = 0;
  int addrErr     = 0;
  int expAddr     = 0;
  int hsFallK, hsWidth, vsFallK, vsWidth, fsK0, fsK1;
  logic prevHs, prevVs;
  expOut_t expV, gotV;
  int mp, mh, mv;

  vga_fb_if fb ();

  vga_scanout #(
    .P_V_VISIBLE (V_VIS),
    .P_V_FRONT   (V_FR),
    .P_V_SYNC    (V_SY),
    .P_V_BACK    (V_BK)
  ) dut (
    .iClock      (clock),
    .iResetn     (resetn),
    .oRdAddr     (fb.rdAddr),
    .iRdData     (fb.rdData),
    .oRed        (oRed),
    .oGreen      (oGreen),
    .oBlue       (oBlue),
    .oHSync      (oHSync),
    .oVSync      (oVSync),
    .oBlank_n    (oBlank_n),
    .oFrameStart (oFrameStart)
  );

  initial clock = 1'b0;
  always #20 clock = ~clock;

  // Synchronous RAM whose contents are simply addr[2:0].
  always @(posedge clock) ramQ <= fb.rdAddr[2:0];
  assign fb.rdData = tieMode ? 3'b101 : ramQ;

  // k = number of clock edges since reset release.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) k <= 0;
    else         k <= k + 1;
  end

  function automatic expOut_t expectAt(input int kk);
    expOut_t e;
    int p, h, v, d;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (kk >= 3) begin
      p = kk - 3;
      h = p % H_TOT;
      v = (p / H_TOT) % V_TOT;
      if (h < 640 && v < V_VIS) begin
        d = ((v / 4) * 160 + h / 4) % 8;
        e.r  = d[2] ? 8'hFF : 8'h00;
        e.g  = d[1] ? 8'hFF : 8'h00;
        e.b  = d[0] ? 8'hFF : 8'h00;
        e.bl = 1'b1;
        e.fs = (h == 0 && v == 0);
      end
      e.hs = !(h >= 656 && h < 752);
      e.vs = !(v >= V_VIS + V_FR && v < V_VIS + V_FR + V_SY);
    end
    return e;
  endfunction

  always @(negedge clock) begin
    if (chkOn) begin
      expV = expectAt(k);
      gotV = {oRed, oGreen, oBlue, oHSync, oVSync, oBlank_n, oFrameStart};
      if (gotV !== expV) begin
        pixErr++;
        if (pixErr == 1)
          $display("[TB] first output divergence at k=%0d got %h want %h", k, gotV, expV);
      end
      if (k == 0) begin
        expAddr = 0;
      end else begin
        mp = k - 1;
        mh = mp % H_TOT;
        mv = (mp / H_TOT) % V_TOT;
        if (mh < 640 && mv < V_VIS) expAddr = (mv / 4) * 160 + mh / 4;
      end
      if (fb.rdAddr !== 15'(expAddr)) begin
        addrErr++;
        if (addrErr == 1)
          $display("[TB] first address divergence at k=%0d got %0d want %0d", k, fb.rdAddr, expAddr);
      end
    end
    if (!resetn) begin
      hsFallK = -1; hsWidth = -1; vsFallK = -1; vsWidth = -1;
      fsK0 = -1; fsK1 = -1;
      prevHs = 1'b1; prevVs = 1'b1;
    end else begin
      if (prevHs && !oHSync && hsFallK < 0) hsFallK = k;
      if (!prevHs && oHSync && hsFallK >= 0 && hsWidth < 0) hsWidth = k - hsFallK;
      if (prevVs && !oVSync && vsFallK < 0) vsFallK = k;
      if (!prevVs && oVSync && vsFallK >= 0 && vsWidth < 0) vsWidth = k - vsFallK;
      if (oFrameStart) begin
        if (fsK0 < 0)      fsK0 = k;
        else if (fsK1 < 0) fsK1 = k;
      end
      prevHs = oHSync;
      prevVs = oVSync;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    assertCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reset is driven between clock edges to keep it clear of sampling.
  task automatic applyStimulus(input logic level);
    @(negedge clock);
    #5 resetn = level;
  endtask

  task automatic waitK(input int target);
    while (k < target) @(negedge clock);
  endtask

  initial begin
    #(40 * 100000);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetn  = 1'b0;
    tieMode = 1'b1;
    chkOn   = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset rdAddr", 32'(fb.rdAddr), 32'd0);
    checkOutput("reset blank_n", 32'(oBlank_n), 32'd0);
    checkOutput("reset hsync", 32'(oHSync), 32'd1);
    checkOutput("reset vsync", 32'(oVSync), 32'd1);
    checkOutput("reset frameStart", 32'(oFrameStart), 32'd0);
    checkOutput("reset colour", 32'({oRed, oGreen, oBlue}), 32'd0);

    applyStimulus(1'b1);
    waitK(2);
    checkOutput("k2 blank_n", 32'(oBlank_n), 32'd0);
    waitK(3);
    checkOutput("k3 blank_n", 32'(oBlank_n), 32'd1);
    checkOutput("k3 red", 32'(oRed), 32'hFF);
    checkOutput("k3 green", 32'(oGreen), 32'h00);
    checkOutput("k3 blue", 32'(oBlue), 32'hFF);
    checkOutput("k3 frameStart", 32'(oFrameStart), 32'd1);

    applyStimulus(1'b0);
    tieMode = 1'b0;
    pixErr  = 0;
    addrErr = 0;
    chkOn   = 1'b1;
    @(negedge clock);
    applyStimulus(1'b1);

    waitK(4);
    checkOutput("addr k4", 32'(fb.rdAddr), 32'd0);
    waitK(5);
    checkOutput("addr k5", 32'(fb.rdAddr), 32'd1);
    waitK(7);
    checkOutput("pixel x1 colour", 32'({oRed, oGreen, oBlue}), 32'h0000FF);
    waitK(799);
    checkOutput("hCount end line0", 32'(dut.w_sync.hCount), 32'd799);
    checkOutput("vCount end line0", 32'(dut.w_sync.vCount), 32'd0);
    waitK(800);
    checkOutput("hCount wrap", 32'(dut.w_sync.hCount), 32'd0);
    checkOutput("vCount step", 32'(dut.w_sync.vCount), 32'd1);
    waitK(3201);
    checkOutput("addr line4 start", 32'(fb.rdAddr), 32'd160);
    waitK(12640);
    checkOutput("addr last visible", 32'(fb.rdAddr), 32'd639);
    waitK(3 + 17 * H_TOT + 100);
    checkOutput("blank line17", 32'(oBlank_n), 32'd0);
    checkOutput("colour line17", 32'({oRed, oGreen, oBlue}), 32'd0);
    waitK(14000);
    checkOutput("addr held in blanking", 32'(fb.rdAddr), 32'd639);
    waitK(FRAME - 1);
    checkOutput("hCount frame end", 32'(dut.w_sync.hCount), 32'd799);
    checkOutput("vCount frame end", 32'(dut.w_sync.vCount), 32'(V_TOT - 1));
    waitK(FRAME);
    checkOutput("hCount frame wrap", 32'(dut.w_sync.hCount), 32'd0);
    checkOutput("vCount frame wrap", 32'(dut.w_sync.vCount), 32'd0);
    waitK(FRAME + 10);
    checkOutput("frameStart first", 32'(fsK0), 32'd3);
    checkOutput("frameStart period", 32'(fsK1 - fsK0), 32'(FRAME));
    checkOutput("hsync fall", 32'(hsFallK), 32'd659);
    checkOutput("hsync width", 32'(hsWidth), 32'd96);
    checkOutput("vsync fall", 32'(vsFallK), 32'(3 + (V_VIS + V_FR) * H_TOT));
    checkOutput("vsync width", 32'(vsWidth), 32'(V_SY * H_TOT));
    checkOutput("frame output errors", 32'(pixErr), 32'd0);
    checkOutput("frame address errors", 32'(addrErr), 32'd0);

    waitK(FRAME + 10 * H_TOT + 300);
    checkOutput("blank before reset", 32'(oBlank_n), 32'd1);
    #5 resetn = 1'b0;
    #1;
    checkOutput("async reset blank_n", 32'(oBlank_n), 32'd0);
    checkOutput("async reset rdAddr", 32'(fb.rdAddr), 32'd0);
    checkOutput("async reset hsync", 32'(oHSync), 32'd1);
    checkOutput("async reset colour", 32'({oRed, oGreen, oBlue}), 32'd0);
    pixErr  = 0;
    addrErr = 0;
    repeat (4) @(negedge clock);
    applyStimulus(1'b1);
    waitK(FRAME + 20);
    checkOutput("restart frameStart", 32'(fsK0), 32'd3);
    checkOutput("restart frameStart next", 32'(fsK1), 32'(FRAME + 3));
    checkOutput("restart output errors", 32'(pixErr), 32'd0);
    checkOutput("restart address errors", 32'(addrErr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
